// File: rtl/ddr4_cmd_issuer.sv
// Host-side DDR4 command/data initiator: turns single-burst read/write requests
// into PRE/ACT/RD/WR sequences with per-bank open-row tracking and fixed DQ timing.
module ddr4_cmd_issuer #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int DQWIDTH   = 64,
    parameter int BL        = 8,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCL       = 6,
    parameter int TCWL      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [BGWIDTH-1:0]       req_bg,
    input  logic [BAWIDTH-1:0]       req_ba,
    input  logic [ADDRWIDTH-1:0]     req_row,
    input  logic [COLWIDTH-1:0]      req_col,
    input  logic [DQWIDTH*BL-1:0]    req_wdata,
    output logic [DQWIDTH*BL-1:0]    rdata,
    output logic                     rdata_valid,
    input  logic                     stall,
    output logic                     cs_n,
    output logic                     act_n,
    output logic [ADDRWIDTH-1:0]     A,
    output logic [BGWIDTH-1:0]       bg,
    output logic [BAWIDTH-1:0]       ba,
    output logic                     cke,
    output logic [DQWIDTH-1:0]       dq_o,
    output logic                     dq_oe,
    input  logic [DQWIDTH-1:0]       dq_i,
    output logic                     dqs_o
);

    localparam int BKW    = BGWIDTH + BAWIDTH;
    localparam int NBANK  = 1 << BKW;
    localparam int MAXT_A = (TRP > TRCD) ? TRP : TRCD;
    localparam int MAXT_B = (TCL > TCWL) ? TCL : TCWL;
    localparam int MAXT   = (MAXT_A > MAXT_B) ? MAXT_A : MAXT_B;
    localparam int CNTW   = $clog2(MAXT + 1);
    localparam int BEATW  = (BL > 1) ? $clog2(BL) : 1;
    // A16..A14 carry RAS_n/CAS_n/WE_n on non-ACT commands
    localparam int A_RAS  = 16;
    localparam int A_CAS  = 15;
    localparam int A_WE   = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_LAT,
        S_DATA
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNTW-1:0]         cnt_reg, cnt_next;
    logic [BEATW-1:0]        beat_reg, beat_next;
    logic                    cke_reg;
    logic                    wr_reg;
    logic [BKW-1:0]          bank_reg;
    logic [ADDRWIDTH-1:0]    row_reg;
    logic [COLWIDTH-1:0]     col_reg;
    logic [DQWIDTH*BL-1:0]   wdata_reg;
    logic [DQWIDTH*BL-1:0]   rbuf_reg;
    logic [DQWIDTH*BL-1:0]   rdata_reg;
    logic [DQWIDTH*BL-1:0]   rcap;
    logic                    rdata_valid_reg;

    logic                    accept;
    logic                    cmd_issue;
    logic                    pre_issue;
    logic                    act_issue;
    logic                    rd_beat;
    logic [BKW-1:0]          req_bank;
    logic [NBANK-1:0]        valid_vec;
    logic [ADDRWIDTH-1:0]    open_row [NBANK];

    assign req_bank  = {req_bg, req_ba};
    assign req_ready = (state_reg == S_IDLE) && cke_reg;
    assign cmd_issue = !stall && ((state_reg == S_PRE) || (state_reg == S_ACT) || (state_reg == S_CAS));
    assign pre_issue = !stall && (state_reg == S_PRE);
    assign act_issue = !stall && (state_reg == S_ACT);
    assign rd_beat   = (state_reg == S_DATA) && !wr_reg;

    // Open-row table: one valid bit and row per {bg,ba}
    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            logic                 valid_reg;
            logic [ADDRWIDTH-1:0] row_q_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    row_q_reg <= '0;
                end else if (pre_issue && (bank_reg == BKW'(gi))) begin
                    valid_reg <= 1'b0;
                end else if (act_issue && (bank_reg == BKW'(gi))) begin
                    valid_reg <= 1'b1;
                    row_q_reg <= row_reg;
                end
            end
            assign valid_vec[gi] = valid_reg;
            assign open_row[gi]  = row_q_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        beat_next  = beat_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (!valid_vec[req_bank])
                        state_next = S_ACT;
                    else if (open_row[req_bank] == req_row)
                        state_next = S_CAS;
                    else
                        state_next = S_PRE;
                end
            end
            S_PRE: begin
                if (!stall) begin
                    if (TRP > 1) begin
                        state_next = S_WAIT_RP;
                        cnt_next   = CNTW'(TRP - 2);
                    end else begin
                        state_next = S_ACT;
                    end
                end
            end
            S_WAIT_RP: begin
                if (cnt_reg == '0)
                    state_next = S_ACT;
                else
                    cnt_next = cnt_reg - CNTW'(1);
            end
            S_ACT: begin
                if (!stall) begin
                    if (TRCD > 1) begin
                        state_next = S_WAIT_RCD;
                        cnt_next   = CNTW'(TRCD - 2);
                    end else begin
                        state_next = S_CAS;
                    end
                end
            end
            S_WAIT_RCD: begin
                if (cnt_reg == '0)
                    state_next = S_CAS;
                else
                    cnt_next = cnt_reg - CNTW'(1);
            end
            S_CAS: begin
                if (!stall) begin
                    beat_next = '0;
                    if (wr_reg) begin
                        if (TCWL > 1) begin
                            state_next = S_LAT;
                            cnt_next   = CNTW'(TCWL - 2);
                        end else begin
                            state_next = S_DATA;
                        end
                    end else begin
                        if (TCL > 1) begin
                            state_next = S_LAT;
                            cnt_next   = CNTW'(TCL - 2);
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end
            end
            S_LAT: begin
                if (cnt_reg == '0) begin
                    state_next = S_DATA;
                    beat_next  = '0;
                end else begin
                    cnt_next = cnt_reg - CNTW'(1);
                end
            end
            S_DATA: begin
                if (beat_reg == BEATW'(BL - 1))
                    state_next = S_IDLE;
                else
                    beat_next = beat_reg + BEATW'(1);
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read burst assembly: current beat merged into the partial buffer
    always_comb begin
        rcap = rbuf_reg;
        rcap[int'(beat_reg) * DQWIDTH +: DQWIDTH] = dq_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            beat_reg        <= '0;
            cke_reg         <= 1'b0;
            wr_reg          <= 1'b0;
            bank_reg        <= '0;
            row_reg         <= '0;
            col_reg         <= '0;
            wdata_reg       <= '0;
            rbuf_reg        <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            beat_reg        <= beat_next;
            cke_reg         <= 1'b1;
            rdata_valid_reg <= 1'b0;
            if (accept) begin
                wr_reg    <= req_wr;
                bank_reg  <= req_bank;
                row_reg   <= req_row;
                col_reg   <= req_col;
                wdata_reg <= req_wdata;
            end
            if (rd_beat) begin
                rbuf_reg <= rcap;
                if (beat_reg == BEATW'(BL - 1)) begin
                    rdata_reg       <= rcap;
                    rdata_valid_reg <= 1'b1;
                end
            end
        end
    end

    // Command bus: driven only on the cycle a command actually issues
    always_comb begin
        cs_n  = 1'b1;
        act_n = 1'b1;
        A     = '0;
        bg    = '0;
        ba    = '0;
        if (cmd_issue) begin
            cs_n = 1'b0;
            bg   = bank_reg[BKW-1 -: BGWIDTH];
            ba   = bank_reg[BAWIDTH-1:0];
            case (state_reg)
                S_ACT: begin
                    act_n = 1'b0;
                    A     = row_reg;
                end
                S_PRE: A[A_CAS] = 1'b1;
                S_CAS: begin
                    A[A_RAS]          = 1'b1;
                    A[A_WE]           = ~wr_reg;
                    A[COLWIDTH-1:0]   = col_reg;
                end
                default: A = '0;
            endcase
        end
    end

    assign cke         = cke_reg;
    assign rdata       = rdata_reg;
    assign rdata_valid = rdata_valid_reg;
    assign dq_oe       = (state_reg == S_DATA) && wr_reg;
    assign dq_o        = dq_oe ? wdata_reg[int'(beat_reg) * DQWIDTH +: DQWIDTH] : '0;
    assign dqs_o       = dq_oe && !beat_reg[0];

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Randomized bench for ddr4_cmd_issuer: a timeline model derived from the command
// spacing rules, plus a small DIMM emulation answering observed RD commands.
module tb_ddr4_cmd_issuer;

    localparam int BGW = 2, BAW = 2, AW = 17, CW = 10, DQW = 64, BL = 8;
    localparam int TRP = 4, TRCD = 4, TCL = 6, TCWL = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [BGW-1:0]       req_bg;
    logic [BAW-1:0]       req_ba;
    logic [AW-1:0]        req_row;
    logic [CW-1:0]        req_col;
    logic [DQW*BL-1:0]    req_wdata;
    logic [DQW*BL-1:0]    rdata;
    logic                 rdata_valid;
    logic                 stall;
    logic                 cs_n;
    logic                 act_n;
    logic [AW-1:0]        A;
    logic [BGW-1:0]       bg;
    logic [BAW-1:0]       ba;
    logic                 cke;
    logic [DQW-1:0]       dq_o;
    logic                 dq_oe;
    logic [DQW-1:0]       dq_i;
    logic                 dqs_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: open rows as the host expects them, and memory contents
    bit   [15:0]          tbl_valid;
    logic [AW-1:0]        tbl_row [16];
    logic [AW-1:0]        dimm_row [16];
    logic [DQW*BL-1:0]    mem [logic [30:0]];

    ddr4_cmd_issuer #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .DQWIDTH(DQW),
        .BL(BL), .TRP(TRP), .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .stall(stall), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .cke(cke), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i), .dqs_o(dqs_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DQW*BL-1:0] mem_get(input logic [30:0] key);
        logic [DQW*BL-1:0] r;
        if (mem.exists(key)) return mem[key];
        for (int k = 0; k < BL; k++)
            r[k*DQW +: DQW] = {1'b0, key, 32'(k) ^ 32'hC0FFEE00};
        return r;
    endfunction

    function automatic logic [DQW*BL-1:0] rand_burst();
        logic [DQW*BL-1:0] r;
        for (int k = 0; k < DQW*BL/32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // One request end-to-end. Stall is held for relative cycles st_lo..st_hi;
    // abort_beat >= 0 pulses reset during that write beat.
    task automatic do_req(input bit wr, input logic [1:0] bgv, input logic [1:0] bav,
                          input logic [AW-1:0] rowv, input logic [CW-1:0] colv,
                          input logic [DQW*BL-1:0] wd, input int st_lo, input int st_hi,
                          input int abort_beat, input string name);
        int kind, t, pre_t, act_t, cas_t, done_t, end_t, rd_t, k, w;
        logic [3:0] bk;
        logic [30:0] key;
        logic [DQW*BL-1:0] exp_rd, rd_burst;
        logic ecs, eact, eoe, edqs;
        logic [AW-1:0] ea;
        logic [DQW-1:0] edq;
        bk  = {bgv, bav};
        key = {bk, rowv, colv};
        w = 0;
        while (!req_ready && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (!req_ready) begin
            $display("FAIL %s accept req_ready got=0 exp=1", name);
            failures++;
            return;
        end
        req_valid = 1'b1; req_wr = wr; req_bg = bgv; req_ba = bav;
        req_row = rowv; req_col = colv; req_wdata = wd; stall = 1'b0;

        // 0 = hit, 1 = closed bank, 2 = row conflict
        kind = !tbl_valid[bk] ? 1 : ((tbl_row[bk] == rowv) ? 0 : 2);
        pre_t = -100; act_t = -100; t = 1;
        if (kind == 2) begin
            while (t >= st_lo && t <= st_hi) t++;
            pre_t = t; t += TRP;
        end
        if (kind != 0) begin
            while (t >= st_lo && t <= st_hi) t++;
            act_t = t; t += TRCD;
        end
        while (t >= st_lo && t <= st_hi) t++;
        cas_t  = t;
        done_t = cas_t + (wr ? TCWL : TCL) + BL;
        end_t  = (abort_beat >= 0) ? cas_t + TCWL + abort_beat + 1 : done_t;
        exp_rd = mem_get(key);
        rd_t = -100; rd_burst = '0;

        for (int n = 1; n <= end_t; n++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            stall = (n >= st_lo && n <= st_hi);
            k = n - rd_t - TCL;
            if (k >= 0 && k < BL) dq_i = rd_burst[k*DQW +: DQW];
            else                  dq_i = {$urandom(), $urandom()};
            if (abort_beat >= 0) reset = (n == end_t - 1);
            @(negedge clk);
            if (abort_beat >= 0 && n == end_t) begin
                checks++;
                if ({req_ready, rdata_valid, cs_n, act_n, A, bg, ba, cke, dq_oe, dqs_o, dq_o} !==
                    {1'b0, 1'b0, 1'b1, 1'b1, 17'h0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 64'h0}) begin
                    $display("FAIL %s n=%0d reset_outputs got=%b_%b_%b_%b_%h_%h_%h_%b_%b_%b_%h exp=all_reset",
                             name, n, req_ready, rdata_valid, cs_n, act_n, A, bg, ba, cke, dq_oe, dqs_o, dq_o);
                    failures++;
                end
                checks++;
                if (rdata !== '0) begin
                    $display("FAIL %s n=%0d reset_rdata got=%h exp=0", name, n, rdata[63:0]);
                    failures++;
                end
            end else begin
                ecs = 1'b1; eact = 1'b1; ea = '0;
                if (n == pre_t) begin ecs = 1'b0; ea = 17'h08000; end
                if (n == act_t) begin ecs = 1'b0; eact = 1'b0; ea = rowv; end
                if (n == cas_t) begin ecs = 1'b0; ea = (wr ? 17'h10000 : 17'h14000) | 17'(colv); end
                checks++;
                if ({cke, cs_n, act_n, A} !== {1'b1, ecs, eact, ea}) begin
                    $display("FAIL %s n=%0d cmd cke/cs_n/act_n/A got=%b/%b/%b/%h exp=1/%b/%b/%h",
                             name, n, cke, cs_n, act_n, A, ecs, eact, ea);
                    failures++;
                end
                if (!ecs) begin
                    checks++;
                    if ({bg, ba} !== {bgv, bav}) begin
                        $display("FAIL %s n=%0d bank got=%h exp=%h", name, n, {bg, ba}, {bgv, bav});
                        failures++;
                    end
                end
                k    = n - (cas_t + TCWL);
                eoe  = wr && k >= 0 && k < BL;
                edqs = eoe && (k % 2 == 0);
                edq  = eoe ? wd[k*DQW +: DQW] : '0;
                checks++;
                if ({dq_oe, dqs_o} !== {eoe, edqs} || (eoe && dq_o !== edq)) begin
                    $display("FAIL %s n=%0d dq oe/dqs/dq got=%b/%b/%h exp=%b/%b/%h",
                             name, n, dq_oe, dqs_o, dq_o, eoe, edqs, edq);
                    failures++;
                end
                checks++;
                if (rdata_valid !== (!wr && n == done_t)) begin
                    $display("FAIL %s n=%0d rdata_valid got=%b exp=%b", name, n, rdata_valid, (!wr && n == done_t));
                    failures++;
                end
                if (!wr && n == done_t) begin
                    checks++;
                    if (rdata !== exp_rd) begin
                        $display("FAIL %s n=%0d rdata beat0 got=%h exp=%h", name, n, rdata[63:0], exp_rd[63:0]);
                        failures++;
                    end
                end
                checks++;
                if (req_ready !== (n == done_t)) begin
                    $display("FAIL %s n=%0d req_ready got=%b exp=%b", name, n, req_ready, (n == done_t));
                    failures++;
                end
            end
            // DIMM side: follow ACTs and answer RDs
            if (!cs_n && act_n && A[16:14] == 3'b101) begin
                rd_t = n;
                rd_burst = mem_get({bg, ba, dimm_row[{bg, ba}], A[9:0]});
            end
            if (!cs_n && !act_n) dimm_row[{bg, ba}] = A;
        end

        if (abort_beat >= 0) begin
            tbl_valid = '0;
        end else begin
            tbl_valid[bk] = 1'b1;
            tbl_row[bk]   = rowv;
            if (wr) mem[key] = wd;
        end
        $display("%s wr=%0d bank=%0d row=%h col=%h kind=%0d cas_at=%0d", name, wr, bk, rowv, colv, kind, cas_t);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; stall = 1'b0; dq_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rdata_valid, cs_n, act_n, A, bg, ba, cke, dq_oe, dqs_o, dq_o} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 17'h0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 64'h0}) begin
            $display("FAIL reset outputs got=%b_%b_%b_%b_%h_%h_%h_%b_%b_%b_%h exp=all_reset",
                     req_ready, rdata_valid, cs_n, act_n, A, bg, ba, cke, dq_oe, dqs_o, dq_o);
            failures++;
        end
        checks++;
        if (rdata !== '0) begin
            $display("FAIL reset rdata got=%h exp=0", rdata[63:0]);
            failures++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cke, req_ready} !== 2'b11) begin
            $display("FAIL reset_release cke/req_ready got=%b/%b exp=1/1", cke, req_ready);
            failures++;
        end
        tbl_valid = '0;
        $display("test_reset done");
    endtask

    task automatic test_write_closed();
        do_req(1'b1, 2'd1, 2'd2, 17'h000A5, 10'h010, rand_burst(), 1, 0, -1, "write_closed");
    endtask

    task automatic test_read_hit();
        do_req(1'b0, 2'd1, 2'd2, 17'h000A5, 10'h010, '0, 1, 0, -1, "read_hit");
    endtask

    task automatic test_read_conflict();
        do_req(1'b0, 2'd1, 2'd2, 17'h00001, 10'h010, '0, 1, 0, -1, "read_conflict");
    endtask

    task automatic test_stall();
        do_req(1'b1, 2'd2, 2'd0, 17'h01234, 10'h03F, rand_burst(), 1, 3, -1, "stall_write");
        do_req(1'b0, 2'd2, 2'd0, 17'h01234, 10'h03F, '0, 1, 2, -1, "stall_read_hit");
    endtask

    task automatic test_reset_mid_write();
        do_req(1'b1, 2'd3, 2'd3, 17'h00077, 10'h005, rand_burst(), 1, 0, 2, "reset_mid_write");
        do_req(1'b0, 2'd1, 2'd2, 17'h00001, 10'h010, '0, 1, 0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [3:0] b1, b2;
        logic [AW-1:0] r1, r2;
        b1 = 4'($urandom_range(0, 15));
        b2 = b1 ^ 4'($urandom_range(1, 15));
        r1 = 17'($urandom());
        r2 = 17'($urandom());
        do_req(1'b1, b1[3:2], b1[1:0], r1, 10'h100, rand_burst(), 1, 0, -1, "b2b_wr_a");
        do_req(1'b1, b2[3:2], b2[1:0], r2, 10'h200, rand_burst(), 1, 0, -1, "b2b_wr_b");
        do_req(1'b0, b1[3:2], b1[1:0], r1, 10'h100, '0, 1, 0, -1, "b2b_rd_a");
        do_req(1'b0, b2[3:2], b2[1:0], r2, 10'h200, '0, 1, 0, -1, "b2b_rd_b");
    endtask

    task automatic test_random();
        int lo, hi;
        logic [3:0] b;
        for (int i = 0; i < 40; i++) begin
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin lo = 1; hi = 0; end
            else begin lo = $urandom_range(1, 8); hi = lo + $urandom_range(0, 3); end
            do_req(1'($urandom_range(0, 1)), b[3:2], b[1:0], 17'($urandom_range(0, 2)),
                   10'($urandom_range(0, 3)), rand_burst(), lo, hi, -1, "random");
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0; req_wdata = '0; stall = 1'b0; dq_i = '0;
        tbl_valid = '0;
        for (int i = 0; i < 16; i++) begin
            tbl_row[i]  = '0;
            dimm_row[i] = '0;
        end
        test_reset();
        test_write_closed();
        test_read_hit();
        test_read_conflict();
        test_stall();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
